// File: rtl/cla_adder_32.sv
// cla_adder_32: 32-bit two-level carry-lookahead adder with registered outputs.
// Computes {cout, sum} = a + b + cin. Eight 4-bit lookahead groups produce group
// generate/propagate, and a second-level unit forms every group carry-in
// directly from them, so there is no ripple between groups.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset (clears all outputs)
//   in_valid  in   operands valid this cycle
//   a, b      in   32-bit unsigned operands
//   cin       in   carry into bit 0
//   out_valid out  registered copy of in_valid
//   sum       out  registered (a + b + cin) mod 2^32, held when in_valid = 0
//   cout      out  registered carry out of bit 31
//   ovf       out  registered signed overflow (carry into bit 31 ^ carry out)
module cla_adder_32 #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned GROUP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NumGroups = WIDTH / GROUP_W;

  // The group equations below are written out for exactly 4 bits x 8 groups.
  generate
    if (WIDTH != 32 || GROUP_W != 4) begin : g_param_check
      $error("cla_adder_32 supports only WIDTH = 32 and GROUP_W = 4");
    end
  endgenerate

  logic [WIDTH-1:0]     p;      // bit propagate
  logic [WIDTH-1:0]     g;      // bit generate
  logic [WIDTH-1:0]     c;      // carry into each bit
  logic [NumGroups-1:0] grp_p;
  logic [NumGroups-1:0] grp_g;
  logic [NumGroups:0]   grp_c;  // carry into each group; grp_c[NumGroups] is cout

  assign p = a ^ b;
  assign g = a & b;

  // First level: group P/G and expanded in-group carries from the group carry-in.
  for (genvar k = 0; k < NumGroups; k++) begin : g_group
    localparam int unsigned B = k * GROUP_W;

    assign grp_p[k] = p[B+3] & p[B+2] & p[B+1] & p[B];
    assign grp_g[k] = g[B+3]
                    | (p[B+3] & g[B+2])
                    | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B]);

    assign c[B]   = grp_c[k];
    assign c[B+1] = g[B] | (p[B] & grp_c[k]);
    assign c[B+2] = g[B+1]
                  | (p[B+1] & g[B])
                  | (p[B+1] & p[B] & grp_c[k]);
    assign c[B+3] = g[B+2]
                  | (p[B+2] & g[B+1])
                  | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & grp_c[k]);
  end

  // Second level: each group carry-in is a flat sum of products of the group
  // G/P terms and cin. Loops unroll into parallel AND-OR trees; no carry
  // feeds another carry.
  always_comb begin
    logic term;
    logic prod;
    grp_c    = '0;
    grp_c[0] = cin;
    for (int k = 0; k < int'(NumGroups); k++) begin
      term = 1'b0;
      for (int j = 0; j <= k; j++) begin
        prod = grp_g[j];
        for (int m = j + 1; m <= k; m++) begin
          prod = prod & grp_p[m];
        end
        term = term | prod;
      end
      prod = cin;
      for (int m = 0; m <= k; m++) begin
        prod = prod & grp_p[m];
      end
      grp_c[k+1] = term | prod;
    end
  end

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  always_comb begin
    sum_d  = p ^ c;
    cout_d = grp_c[NumGroups];
    ovf_d  = c[WIDTH-1] ^ grp_c[NumGroups];
  end

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_cla_adder_32.sv
// tb_cla_adder_32: self-checking bench for cla_adder_32. Directed rows carry
// hand-computed expectations; random traffic is checked against a reference
// model built on plain 33-bit integer addition and the sign rule for overflow.
module tb_cla_adder_32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  // Reference state: last accepted result and whether the previous edge was valid.
  logic [31:0] exp_sum   = '0;
  logic        exp_cout  = 1'b0;
  logic        exp_ovf   = 1'b0;
  logic        exp_valid = 1'b0;

  cla_adder_32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: 33-bit arithmetic sum; overflow when both operands share a sign
  // and the 32-bit result's sign differs.
  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci);
    logic [32:0] full;
    logic        o;
    full = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    o    = (x[31] == y[31]) && (full[31] != x[31]);
    return {o, full};
  endfunction

  // Apply one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y,
                       input logic ci);
    logic [33:0] r;
    in_valid = v;
    a        = x;
    b        = y;
    cin      = ci;
    @(posedge clk);
    #1;
    r = ref_add(x, y, ci);
    if (rst_n) begin
      exp_valid = v;
      if (v) begin
        exp_sum  = r[31:0];
        exp_cout = r[32];
        exp_ovf  = r[33];
      end
    end
  endtask

  task automatic add_row(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic ci, input logic [31:0] es, input logic ec,
                         input logic eo);
    drive(1'b1, x, y, ci);
    chk({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
    chk({tag, "_sum"}, 64'(sum), 64'(es));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'(exp_valid));
    chk({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    chk({tag, "_cout"}, 64'(cout), 64'(exp_cout));
    chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;

    // Load a nonzero result, then reset between edges and check it clears at once.
    #2;
    in_valid = 1'b1;
    a        = 32'hFFFF_FFFF;
    b        = 32'hFFFF_FFFF;
    cin      = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_sum", 64'(sum), 64'h0);
    chk("rst_cout", 64'(cout), 64'h0);
    chk("rst_ovf", 64'(ovf), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic adds.
    add_row("zero",     32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    add_row("one_one",  32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    add_row("one_cin",  32'h0000_0001, 32'h0000_0001, 1'b1, 32'h0000_0003, 1'b0, 1'b0);
    add_row("nib_cry",  32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0, 1'b0);
    // Carry propagation across groups.
    add_row("half_cry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    add_row("full_cry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    add_row("prop_cin", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    add_row("max_cin",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    // Saturated, identity, signed overflow.
    add_row("sat",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
    add_row("ident",    32'h0000_0000, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
    add_row("sovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    add_row("novf",     32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

    // Handshake: one valid pulse, then three idle cycles with changing operands.
    add_row("pulse",    32'h1111_1111, 32'h2222_2222, 1'b1, 32'h3333_3334, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, $urandom(), $urandom(), 1'b1);
      chk("idle_valid", 64'(out_valid), 64'h0);
      chk("idle_sum", 64'(sum), 64'h3333_3334);
      chk("idle_cout", 64'(cout), 64'h0);
    end

    // Reset mid-stream: result in flight is dropped, outputs clear immediately.
    drive(1'b1, 32'hDEAD_BEEF, 32'h8000_0001, 1'b0);
    chk_model("pre_rst");
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", 64'(sum), 64'h0);
    chk("mid_rst_cout", 64'(cout), 64'h0);
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    @(posedge clk);
    #1;
    chk("held_rst_sum", 64'(sum), 64'h0);
    chk("held_rst_valid", 64'(out_valid), 64'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    exp_sum   = '0;
    exp_cout  = 1'b0;
    exp_ovf   = 1'b0;
    exp_valid = 1'b0;
    drive(1'b0, 32'h0000_0005, 32'h0000_0006, 1'b0);
    chk_model("post_rst_idle");

    // Randomized traffic; some operands bias toward long propagate chains.
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] x;
      logic [31:0] y;
      x = $urandom();
      case ($urandom_range(0, 3))
        0:       y = ~x;
        1:       y = ~x ^ (32'h1 << $urandom_range(0, 31));
        default: y = $urandom();
      endcase
      drive(1'($urandom_range(0, 1)), x, y, 1'($urandom_range(0, 1)));
      chk_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_adder_32.md
Name: cla_adder_32

Overview:
- 32-bit carry-lookahead adder with registered outputs: computes {cout, sum} = a + b + cin.
- Two-level lookahead: eight 4-bit CLA groups; group generate/propagate feed a second-level lookahead unit that produces all group carry-ins in parallel. No ripple between groups.
- Used as the datapath adder in ALU / address paths; one clock, single-cycle registered result.

Parameters:
- WIDTH, 32, operand width; only 32 is supported, elaborate-time error otherwise.
- GROUP_W, 4, bits per first-level lookahead group; fixed at 4, giving 8 groups.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- a  input  32  operand A, unsigned
- b  input  32  operand B, unsigned
- cin  input  1  carry into bit 0
- out_valid  output  1  sum/cout valid; registered copy of in_valid
- sum  output  32  registered (a + b + cin) mod 2^32
- cout  output  1  registered carry out of bit 31
- ovf  output  1  registered signed overflow: carry into bit 31 XOR carry out of bit 31

Behaviour:
- Reset: asserting rst_n low immediately clears sum, cout, ovf and out_valid to 0, with no clock needed. Outputs hold 0 while rst_n is low. The first capture happens on the first rising clk edge after rst_n goes high.
- Bit level: p[i] = a[i] ^ b[i]; g[i] = a[i] & b[i]; s[i] = p[i] ^ c[i]; c[0] = cin.
- Group level (k = 0..7): in-group carries are expanded lookahead equations from the group carry-in.
  - Group P = AND of the four p.
  - Group G = g3 | p3g2 | p3p2g1 | p3p2p1g0.
- Second level: each group carry-in C[k+1] = G[k] | P[k]C[k], written as expanded sum-of-products per group, not chained. C[0] = cin and cout = C[8].
- The combinational result must equal the 33-bit sum {1'b0,a} + {1'b0,b} + cin for every input.
- Timing: operands sampled on a rising clk edge when in_valid = 1. The result appears on sum/cout/ovf on that edge, so latency is 1 cycle. out_valid follows in_valid with 1-cycle latency.
- in_valid = 0 on an edge: sum/cout/ovf hold their previous values and out_valid goes to 0.
- Back-to-back valid operands are accepted every cycle; there is no backpressure and no stall.
- Wrap-around: results are modulo 2^32, with the 33rd bit on cout. cin = 1 with a = b = FFFFFFFF gives sum FFFFFFFF, cout 1.
- Reset mid-operation: an in-flight result is discarded and out_valid = 0 until the next valid capture after reset release.
- No X propagation from reset state: all output flops are reset.

Test Plan:
- Reset: drive rst_n = 0 asynchronously between edges -> sum = 00000000, cout = 0, ovf = 0 and out_valid = 0 immediately, before any clk edge.
- Basic adds, one per cycle with in_valid = 1 (each row: a, b, cin -> sum, cout, ovf, checked one cycle later with out_valid = 1):
  - 00000000, 00000000, 0 -> 00000000, 0, 0
  - 00000001, 00000001, 0 -> 00000002, 0, 0
  - 00000001, 00000001, 1 -> 00000003, 0, 0
  - 0000000F, 00000001, 0 -> 00000010, 0, 0
- Carry propagation across groups:
  - 0000FFFF + 00000001, cin = 0 -> 00010000, cout 0.
  - FFFFFFFF + 00000001, cin = 0 -> 00000000, cout 1, ovf 0.
  - A5A5A5A5 + 5A5A5A5A, cin = 1 -> 00000000, cout 1 (full-width propagate chain driven by cin).
- Saturated and identity operands:
  - FFFFFFFF + FFFFFFFF, cin = 0 -> FFFFFFFE, cout 1.
  - 00000000 + 12345678, cin = 0 -> 12345678, cout 0.
  - Signed overflow: 7FFFFFFF + 00000001 -> 80000000, cout 0, ovf 1.
- Handshake: pulse in_valid for one cycle, then hold it low for 3 cycles with changing a/b -> out_valid high for exactly one cycle and sum/cout stay frozen afterward. Then assert rst_n mid-stream -> outputs return to 0 at once.
- Randomized: 10,000 random a, b, cin with in_valid random -> each valid result matches a 33-bit reference sum one cycle later.
